// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl
//   Sequencer for the board's 3-input custom logic component. It steps the
//   component inputs {a,b,c} through all eight combinations. Each vector is
//   held for SETTLE cycles, then f is captured into an 8-bit truth table and
//   compared against EXPECTED.
//
// Parameters
//   SETTLE      cycles each vector is held before f is sampled (1..255)
//   EXPECTED    expected truth table, bit i = f for {a,b,c} = i
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start        request a sweep (only honoured in IDLE)
//   abort        terminate a sweep in progress / suppress loop at DONE
//   loop         restart automatically when a sweep completes
//   f            output of the component under control
//   a, b, c      vector driven to the component ({a,b,c} = vec_idx)
//   vec_idx      current vector index
//   busy         sweep in progress
//   done         one-cycle pulse on sweep completion
//   pass         last completed sweep matched EXPECTED
//   truth_table  captured f values
//   mismatch     per-vector truth_table ^ EXPECTED
//   fail_count   failed sweeps since reset, saturating at 255
//
// All outputs come straight from flops; the combinational block only computes
// next-register values.

module logic_sweep_ctrl #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [7:0]  EXPECTED = 8'hA6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       loop,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] truth_table,
    output logic [7:0] mismatch,
    output logic [7:0] fail_count
);

    localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [7:0] settle_cnt, settle_cnt_nx;
    logic [2:0] vec_idx_nx;
    logic       busy_nx, done_nx, pass_nx;
    logic [7:0] truth_table_nx, mismatch_nx, fail_count_nx;
    logic       launch;

    // The component inputs always equal the registered vector index:
    // zero in IDLE, the swept vector in DRIVE, 7 during the DONE cycle.
    assign {a, b, c} = vec_idx;

    always_comb begin
        state_nx       = state;
        settle_cnt_nx  = settle_cnt;
        vec_idx_nx     = vec_idx;
        busy_nx        = busy;
        done_nx        = 1'b0;
        pass_nx        = pass;
        truth_table_nx = truth_table;
        mismatch_nx    = mismatch;
        fail_count_nx  = fail_count;
        launch         = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    launch = 1'b1;
                end
            end

            DRIVE: begin
                if (abort) begin
                    // Partial truth_table/mismatch are kept for inspection.
                    state_nx   = IDLE;
                    busy_nx    = 1'b0;
                    pass_nx    = 1'b0;
                    vec_idx_nx = '0;
                end else if (settle_cnt != '0) begin
                    settle_cnt_nx = settle_cnt - 8'd1;
                end else begin
                    truth_table_nx[vec_idx] = f;
                    mismatch_nx[vec_idx]    = f ^ EXPECTED[vec_idx];
                    if (vec_idx == 3'd7) begin
                        // pass and fail_count use the post-capture mismatch so
                        // vector 7 is included in the same edge as done.
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (mismatch_nx == '0);
                        if (mismatch_nx != '0 && fail_count != 8'hFF) begin
                            fail_count_nx = fail_count + 8'd1;
                        end
                    end else begin
                        vec_idx_nx    = vec_idx + 3'd1;
                        settle_cnt_nx = RELOAD;
                    end
                end
            end

            DONE: begin
                if (loop && !abort) begin
                    launch = 1'b1;
                end else begin
                    state_nx   = IDLE;
                    vec_idx_nx = '0;
                end
            end

            default: begin
                state_nx   = IDLE;
                busy_nx    = 1'b0;
                vec_idx_nx = '0;
            end
        endcase

        // Common sweep initialisation for a start from IDLE or a loop restart.
        if (launch) begin
            state_nx       = DRIVE;
            vec_idx_nx     = '0;
            settle_cnt_nx  = RELOAD;
            busy_nx        = 1'b1;
            pass_nx        = 1'b0;
            truth_table_nx = '0;
            mismatch_nx    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            vec_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            truth_table <= '0;
            mismatch    <= '0;
            fail_count  <= '0;
        end else begin
            state       <= state_nx;
            settle_cnt  <= settle_cnt_nx;
            vec_idx     <= vec_idx_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            pass        <= pass_nx;
            truth_table <= truth_table_nx;
            mismatch    <= mismatch_nx;
            fail_count  <= fail_count_nx;
        end
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Self-checking bench for logic_sweep_ctrl. Three instances with SETTLE of
// 2, 1 and 5 are driven by stub components whose f is a programmable truth
// table, optionally delayed by a number of cycles.

module tb_logic_sweep_ctrl;

    localparam logic [7:0] EXP = 8'hA6;

    logic clk = 1'b0;
    logic reset, abort, loop;
    logic       start_v [3];
    logic       f_v     [3];
    logic       a_v     [3];
    logic       b_v     [3];
    logic       c_v     [3];
    logic [2:0] abc_v   [3];
    logic [2:0] vec_v   [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       pass_v  [3];
    logic [7:0] tt_v    [3];
    logic [7:0] mm_v    [3];
    logic [7:0] fc_v    [3];

    int         settle_of [3] = '{2, 1, 5};
    logic [7:0] tbl       [3];
    int         dly       [3];
    int         fc_model  [3];
    logic [2:0] hist      [3][8];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic_sweep_ctrl #(
            .SETTLE  (k == 0 ? 2 : (k == 1 ? 1 : 5)),
            .EXPECTED(8'hA6)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start_v[k]),
            .abort      (abort),
            .loop       (loop),
            .f          (f_v[k]),
            .a          (a_v[k]),
            .b          (b_v[k]),
            .c          (c_v[k]),
            .vec_idx    (vec_v[k]),
            .busy       (busy_v[k]),
            .done       (done_v[k]),
            .pass       (pass_v[k]),
            .truth_table(tt_v[k]),
            .mismatch   (mm_v[k]),
            .fail_count (fc_v[k])
        );
    end

    // Stub component: f = tbl[{a,b,c}] as seen dly cycles ago.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            hist[k][0] <= abc_v[k];
            for (int j = 1; j < 8; j++) hist[k][j] <= hist[k][j-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            abc_v[k] = {a_v[k], b_v[k], c_v[k]};
            f_v[k]   = (dly[k] == 0) ? tbl[k][abc_v[k]] : tbl[k][hist[k][dly[k]-1]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input int k);
        chk($sformatf("rst_vec%0d", k),  vec_v[k],  0);
        chk($sformatf("rst_abc%0d", k),  abc_v[k],  0);
        chk($sformatf("rst_busy%0d", k), busy_v[k], 0);
        chk($sformatf("rst_done%0d", k), done_v[k], 0);
        chk($sformatf("rst_pass%0d", k), pass_v[k], 0);
        chk($sformatf("rst_tt%0d", k),   tt_v[k],   0);
        chk($sformatf("rst_mm%0d", k),   mm_v[k],   0);
        chk($sformatf("rst_fc%0d", k),   fc_v[k],   0);
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
    endtask

    // One full sweep with loop=0; checks vector timing, done latency and
    // final results against the stub table t.
    task automatic run_sweep(input int k, input logic [7:0] t, input int d);
        int s;
        logic [7:0] exp_mm;
        s      = settle_of[k];
        tbl[k] = t;
        dly[k] = d;
        exp_mm = t ^ EXP;
        pulse_start(k);
        chk("start_busy", busy_v[k], 1);
        chk("start_vec",  vec_v[k],  0);
        chk("start_tt",   tt_v[k],   0);
        chk("start_mm",   mm_v[k],   0);
        chk("start_pass", pass_v[k], 0);
        for (int n = 1; n <= 8 * s; n++) begin
            tick();
            if (n < 8 * s) begin
                chk("sweep_vec",  vec_v[k],  n / s);
                chk("sweep_abc",  abc_v[k],  n / s);
                chk("sweep_busy", busy_v[k], 1);
                chk("sweep_done", done_v[k], 0);
            end
        end
        if (exp_mm != 8'h00 && fc_model[k] < 255) fc_model[k]++;
        chk("end_done", done_v[k], 1);
        chk("end_busy", busy_v[k], 0);
        chk("end_tt",   tt_v[k],   t);
        chk("end_mm",   mm_v[k],   exp_mm);
        chk("end_pass", pass_v[k], exp_mm == 8'h00);
        chk("end_fc",   fc_v[k],   fc_model[k]);
        tick();
        chk("post_done", done_v[k], 0);
        chk("post_busy", busy_v[k], 0);
        chk("post_tt",   tt_v[k],   t);
        chk("post_pass", pass_v[k], exp_mm == 8'h00);
    endtask

    task automatic wait_done(input int k, input int expect_n, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_v[k] && n < 1000);
        chk(tag, n, expect_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] t;
        reset = 1'b1;
        abort = 1'b0;
        loop  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_v[k]  = 1'b0;
            tbl[k]      = 8'h00;
            dly[k]      = 0;
            fc_model[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_reset_state(k);
        @(negedge clk);
        reset = 1'b0;

        // Correct component, then stuck-at-0, then random tables.
        run_sweep(0, EXP, 0);
        run_sweep(0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            t = (i % 3 == 2) ? EXP : 8'($urandom);
            run_sweep(0, t, 0);
        end

        // SETTLE=1: correct sweep, then saturate fail_count.
        run_sweep(1, EXP, 0);
        for (int i = 0; i < 300; i++) run_sweep(1, 8'h00, 0);
        chk("fc_saturated", fc_v[1], 255);

        // SETTLE=5 with a component that settles after 4 cycles.
        run_sweep(2, EXP, 4);
        run_sweep(2, 8'($urandom), 4);

        // Abort while vector 3 is driven.
        fc_model[0] = fc_v[0];
        tbl[0] = EXP;
        pulse_start(0);
        repeat (6) tick();
        chk("abort_pre_vec", vec_v[0], 3);
        @(negedge clk);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy_v[0], 0);
        chk("abort_done", done_v[0], 0);
        chk("abort_pass", pass_v[0], 0);
        chk("abort_tt",   tt_v[0],   EXP & 8'h07);
        chk("abort_mm",   mm_v[0],   8'h00);
        chk("abort_fc",   fc_v[0],   fc_model[0]);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_v[0] || busy_v[0]) cnt++;
        end
        chk("abort_quiet", cnt, 0);

        // start and abort together in IDLE.
        @(negedge clk);
        start_v[0] = 1'b1;
        abort      = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort      = 1'b0;
        chk("start_abort_busy", busy_v[0], 0);
        tick();
        chk("start_abort_busy2", busy_v[0], 0);

        // Looping sweeps: 17-cycle period, mid-sweep start ignored,
        // dropping loop ends after the current sweep.
        loop = 1'b1;
        pulse_start(0);
        wait_done(0, 16, "loop_done1");
        chk("loop_pass1", pass_v[0], 1);
        repeat (3) tick();
        pulse_start(0);
        wait_done(0, 13, "loop_done2");
        chk("loop_pass2", pass_v[0], 1);
        repeat (3) tick();
        @(negedge clk);
        loop = 1'b0;
        wait_done(0, 14, "loop_done3");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_v[0] || busy_v[0]) cnt++;
        end
        chk("loop_stopped", cnt, 0);

        // Reset while vector 5 is driven, then a normal sweep.
        tbl[0] = 8'($urandom);
        pulse_start(0);
        repeat (10) tick();
        chk("reset_pre_vec", vec_v[0], 5);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk_reset_state(0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) fc_model[k] = 0;
        run_sweep(0, 8'($urandom), 0);
        run_sweep(0, EXP, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_sweep_ctrl.md
# logic_sweep_ctrl

Sequencer that exhaustively exercises the 3-input custom logic component on the board. It drives the component's `a`, `b`, `c` inputs through all eight combinations, holds each vector for a programmable settle time, captures `f` into an 8-bit truth table and compares it against the expected function. It sits between the lab's switch/button front end and the logic component, and reports pass/fail plus per-vector mismatches to the LED/display logic.

## Interface
- `SETTLE`, 2: cycles each vector is held before `f` is sampled. Legal range 1..255.
- `EXPECTED`, 8'hA6: expected truth table. Bit `i` = `f` for `{a,b,c} = i`. 8'hA6 matches f = (a&c)|(~a&b&~c)|(~b&c).

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a sweep. Sampled only in IDLE.
- `abort` input 1: terminate an in-progress sweep.
- `loop` input 1: when high at sweep end, the next sweep starts automatically.
- `f` input 1: output of the logic component under control.
- `a`, `b`, `c` output 1 each: vector driven to the component, `{a,b,c} = vec_idx`.
- `vec_idx` output 3: current vector index.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: one-cycle pulse when a sweep completes.
- `pass` output 1: last completed sweep matched `EXPECTED`.
- `truth_table` output 8: captured `f` values.
- `mismatch` output 8: `truth_table ^ EXPECTED`, accumulated per vector.
- `fail_count` output 8: number of failed sweeps since reset, saturating at 255.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- **IDLE**
  - `busy=0`; `{a,b,c}=000`.
  - On `start=1 && abort=0`: go to DRIVE, set `vec_idx=0`, load settle counter with `SETTLE-1`, clear `truth_table`, `mismatch` and `pass`.
- **DRIVE**
  - `busy=1`; `{a,b,c}=vec_idx`.
  - Counter != 0: decrement.
  - Counter == 0: write `f` into `truth_table[vec_idx]` and `mismatch[vec_idx] = f ^ EXPECTED[vec_idx]`.
  - If `vec_idx==7`, go to DONE. Otherwise increment `vec_idx` and reload the counter.
- **DONE** (lasts one cycle)
  - `done=1`, `busy=0`.
  - `pass = (mismatch==0)`, computed from the final registered values including vector 7.
  - If the sweep failed, `fail_count` increments (saturating).
  - Next state: if `loop=1 && abort=0`, go to DRIVE with the same initialisation as a start. Otherwise go to IDLE.
- **abort**
  - `abort=1` in DRIVE: next state is IDLE. No `done` pulse, `pass=0`, `fail_count` unchanged. Partial `truth_table`/`mismatch` are retained.
  - `abort` in DONE suppresses `loop`.
- `start` while busy or in DONE is ignored. `start` and `abort` together in IDLE: `abort` wins, so the sweep does not start.
- `reset` in any state forces IDLE and the reset values, regardless of other inputs.
- `vec_idx` never wraps past 7 within a sweep.

## Timing
- Reset values: `a=b=c=0`, `vec_idx=0`, `busy=0`, `done=0`, `pass=0`, `truth_table=0`, `mismatch=0`, `fail_count=0`, state IDLE.
- All outputs are registered, with no combinational path from any input to any output.
- `start` is accepted at edge T0. `busy` and vector 0 are visible from T0.
- Vector `i` is driven from edge T0+i·SETTLE. `f` is sampled at edge T0+(i+1)·SETTLE.
- The component's `f` must be valid within `SETTLE` cycles of a vector change.
- `done` and `pass` are valid in the cycle after edge T0+8·SETTLE. With default `SETTLE=2`, `done` is high 16 cycles after the start edge.
- Back-to-back sweeps with `loop`: each sweep is 8·SETTLE+1 cycles (DONE adds one cycle).
- `pass`, `truth_table` and `mismatch` hold their values until the next accepted start, loop restart or reset.

## Test plan
- Default params, correct component (f per EXPECTED), pulse `start`: `{a,b,c}` steps 000..111, 2 cycles each; `done` pulses 16 cycles after start; `truth_table=8'hA6`, `mismatch=0`, `pass=1`, `fail_count=0`.
- Stub `f` stuck at 0: `truth_table=8'h00`, `mismatch=8'hA6`, `pass=0`, `fail_count=1`. Repeat 300 sweeps: `fail_count` saturates at 255.
- `SETTLE=1`: `done` 8 cycles after start. `SETTLE=5`: `done` 40 cycles after start. Stub `f` delayed 4 cycles with `SETTLE=5` gives `pass=1`.
- Assert `abort` while `vec_idx=3`: `busy=0` next cycle, no `done`, `pass=0`, `truth_table[2:0]` equals `3'b110`, `fail_count` unchanged. `start` and `abort` together in IDLE: stays IDLE.
- `loop=1`: `done` pulses every 17 cycles with `SETTLE=2`. Pulsing `start` mid-sweep has no effect. Dropping `loop` ends after the current sweep.
- `reset` asserted mid-sweep at `vec_idx=5`: next cycle all outputs at reset values. A subsequent `start` produces a normal sweep.
